// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter family.
//   DIR_UP / DIR_DN : encodings of the 'up' direction input
//   clog2()         : ceiling log2, usable in elaboration-time expressions
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Number of bits needed to hold values 0..value-1. Returns 0 for value <= 1.
  function automatic int unsigned clog2(input longint unsigned value);
    longint unsigned v;
    int unsigned     n;
    n = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

endpackage : counter_pkg

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
// Synchronous modulo-N up/down counter with parallel load, wrap-or-saturate
// behaviour at the range ends, a combinational terminal-count output and a
// sticky range-end flag.
//
// Parameters
//   WIDTH    : counter width in bits (1..32)
//   MODULUS  : count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE : 0 = wrap at range ends, 1 = hold at range ends
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : asynchronous active-low reset (q=0, ovf=0)
//   en       : count enable
//   up       : direction, 1 = up, 0 = down
//   load     : synchronous load, takes priority over en
//   load_val : value to load, clamped to MODULUS-1
//   clr_ovf  : clears ovf (a simultaneous range-end event wins)
//   q        : registered count
//   tc       : terminal count, high in the cycle before a range-end event
//   ovf      : sticky range-end flag
// -----------------------------------------------------------------------------
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  // Reject illegal parameterisations while elaborating.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  // Range constants held one bit wider than q so MODULUS = 2**WIDTH is exact.
  localparam longint unsigned MAX_L = MODULUS - 1;
  localparam logic [WIDTH:0]  MOD_W = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]  MAX_W = MAX_L[WIDTH:0];
  localparam logic [WIDTH:0]  ONE_W = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_unused_msb;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_load_ok;
  logic             w_range_end;
  logic [WIDTH-1:0] w_q_next;
  logic             w_ovf_next;

  assign w_q_ext   = {1'b0, q};
  assign w_inc     = w_q_ext + ONE_W;
  assign w_dec     = w_q_ext - ONE_W;
  // The extra bit never sets on the paths that use these results: increment
  // is only taken below MAX, decrement only above zero.
  assign w_unused_msb = w_inc[WIDTH] ^ w_dec[WIDTH];

  assign w_at_max  = (w_q_ext == MAX_W);
  assign w_at_zero = (q == '0);
  assign w_load_ok = ({1'b0, load_val} < MOD_W);

  // A range-end event is an enabled, unloaded step off either end of the range.
  assign w_range_end = en & ~load &
                       (((up == DIR_UP) & w_at_max) | ((up == DIR_DN) & w_at_zero));
  assign tc = w_range_end;

  // NOTE: every signal written in always_comb gets a default on entry, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_q_next   = q;
    w_ovf_next = ovf & ~clr_ovf;

    if (load) begin
      w_q_next = w_load_ok ? load_val : MAX_W[WIDTH-1:0];
    end else if (en) begin
      if (up == DIR_UP) begin
        if (w_at_max) w_q_next = SATURATE ? q : '0;
        else          w_q_next = w_inc[WIDTH-1:0];
      end else begin
        if (w_at_zero) w_q_next = SATURATE ? q : MAX_W[WIDTH-1:0];
        else           w_q_next = w_dec[WIDTH-1:0];
      end
    end

    // Set beats clear when both happen on the same edge.
    if (w_range_end) w_ovf_next = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= w_q_next;
      ovf <= w_ovf_next;
    end
  end

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_mod_counter
// Directed bench for updown_mod_counter. Three instances share the stimulus:
//   dut_a : WIDTH=4, MODULUS=16, SATURATE=0
//   dut_b : WIDTH=4, MODULUS=10, SATURATE=0
//   dut_c : WIDTH=4, MODULUS=10, SATURATE=1
// Each scenario only checks the instance it targets. Inputs change and
// outputs are sampled on the falling edge; tc is sampled 1 ns after inputs
// settle, ahead of the rising edge that consumes them.
// -----------------------------------------------------------------------------
module tb_updown_mod_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       clr_ovf;

  logic [3:0] q_a, q_b, q_c;
  logic       tc_a, tc_b, tc_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .q(q_a), .tc(tc_a), .ovf(ovf_a)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .q(q_b), .tc(tc_b), .ovf(ovf_b)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .q(q_c), .tc(tc_c), .ovf(ovf_c)
  );

  // Idle inputs, reset across one rising edge, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; up = DIR_UP; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up = DIR_DN; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
    #1;
    n_tests++;
    if (q_a !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", q_a); end
    n_tests++;
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_a); end
    // During reset q=0, so en=1 with down direction must raise tc.
    n_tests++;
    if (tc_a !== 1'b1) begin n_fail++; $display("FAIL reset_tc_down: got %b want 1", tc_a); end
    up = DIR_UP;
    #1;
    n_tests++;
    if (tc_a !== 1'b0) begin n_fail++; $display("FAIL reset_tc_up: got %b want 0", tc_a); end
    @(negedge clk);
    n_tests++;
    if (q_a !== 4'd0) begin n_fail++; $display("FAIL reset_hold_q: got %0d want 0", q_a); end
    en = 1'b0;
    rst = 1'b1;
  endtask

  // Mod-16 up count: 17 edges give 1..15, 0, 1; tc only while q=15.
  task automatic test_wrap_up();
    do_reset();
    en = 1'b1; up = DIR_UP;
    for (int i = 1; i <= 17; i++) begin
      #1;
      n_tests++;
      if (tc_a !== (i == 16)) begin
        n_fail++; $display("FAIL wrap_up_tc[%0d]: got %b want %b", i, tc_a, (i == 16));
      end
      @(negedge clk);
      n_tests++;
      if (q_a !== 4'(i % 16)) begin
        n_fail++; $display("FAIL wrap_up_q[%0d]: got %0d want %0d", i, q_a, i % 16);
      end
      n_tests++;
      if (ovf_a !== (i >= 16)) begin
        n_fail++; $display("FAIL wrap_up_ovf[%0d]: got %b want %b", i, ovf_a, (i >= 16));
      end
    end
    en = 1'b0;
  endtask

  // Mod-10 down from 0 wraps to 9 and sets ovf; clr_ovf then clears it.
  task automatic test_down_wrap();
    do_reset();
    en = 1'b1; up = DIR_DN;
    #1;
    n_tests++;
    if (tc_b !== 1'b1) begin n_fail++; $display("FAIL down_tc: got %b want 1", tc_b); end
    @(negedge clk);
    n_tests++;
    if (q_b !== 4'd9) begin n_fail++; $display("FAIL down_wrap_q: got %0d want 9", q_b); end
    n_tests++;
    if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL down_wrap_ovf: got %b want 1", ovf_b); end
    en = 1'b0; clr_ovf = 1'b1;
    #1;
    n_tests++;
    if (tc_b !== 1'b0) begin n_fail++; $display("FAIL idle_tc: got %b want 0", tc_b); end
    @(negedge clk);
    clr_ovf = 1'b0;
    n_tests++;
    if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", ovf_b); end
    n_tests++;
    if (q_b !== 4'd9) begin n_fail++; $display("FAIL clr_hold_q: got %0d want 9", q_b); end
  endtask

  // Saturating mod-10: load 7, five up edges give 8, 9, 9, 9, 9.
  task automatic test_saturate();
    logic [3:0] exp_q [5] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    do_reset();
    load = 1'b1; load_val = 4'd7;
    @(negedge clk);
    load = 1'b0;
    n_tests++;
    if (q_c !== 4'd7) begin n_fail++; $display("FAIL sat_load: got %0d want 7", q_c); end
    en = 1'b1; up = DIR_UP;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (q_c !== exp_q[k]) begin
        n_fail++; $display("FAIL sat_q[%0d]: got %0d want %0d", k, q_c, exp_q[k]);
      end
      n_tests++;
      if (ovf_c !== (k >= 2)) begin
        n_fail++; $display("FAIL sat_ovf[%0d]: got %b want %b", k, ovf_c, (k >= 2));
      end
    end
    en = 1'b0;
  endtask

  // Load beats count and clamps out-of-range values to MODULUS-1.
  task automatic test_load_clamp();
    do_reset();
    load = 1'b1; load_val = 4'd12; en = 1'b1; up = DIR_UP;
    @(negedge clk);
    n_tests++;
    if (q_b !== 4'd9) begin n_fail++; $display("FAIL load_clamp: got %0d want 9", q_b); end
    // q=9 at the top with en=1 up=1, but load suppresses tc and the event.
    load_val = 4'd3;
    #1;
    n_tests++;
    if (tc_b !== 1'b0) begin n_fail++; $display("FAIL load_tc: got %b want 0", tc_b); end
    @(negedge clk);
    n_tests++;
    if (q_b !== 4'd3) begin n_fail++; $display("FAIL load_3: got %0d want 3", q_b); end
    n_tests++;
    if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL load_ovf: got %b want 0", ovf_b); end
    load = 1'b0;
    @(negedge clk);
    n_tests++;
    if (q_b !== 4'd4) begin n_fail++; $display("FAIL load_then_count: got %0d want 4", q_b); end
    en = 1'b0;
  endtask

  // clr_ovf on the same edge as a wrap: set wins.
  task automatic test_clr_vs_set();
    do_reset();
    load = 1'b1; load_val = 4'd15;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = DIR_UP; clr_ovf = 1'b1;
    @(negedge clk);
    n_tests++;
    if (q_a !== 4'd0) begin n_fail++; $display("FAIL clr_set_q: got %0d want 0", q_a); end
    n_tests++;
    if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL clr_set_ovf: got %b want 1", ovf_a); end
    en = 1'b0;
    @(negedge clk);
    clr_ovf = 1'b0;
    n_tests++;
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL clr_after: got %b want 0", ovf_a); end
  endtask

  // Direction change takes effect on the next enabled edge; en=0 holds.
  task automatic test_direction();
    logic       dir_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_seq [6] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd0};
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      up = dir_seq[k];
      @(negedge clk);
      n_tests++;
      if (q_a !== exp_seq[k]) begin
        n_fail++; $display("FAIL dir_q[%0d]: got %0d want %0d", k, q_a, exp_seq[k]);
      end
    end
    en = 1'b0; up = DIR_DN;
    @(negedge clk);
    up = DIR_UP;
    @(negedge clk);
    n_tests++;
    if (q_a !== 4'd0) begin n_fail++; $display("FAIL hold_q: got %0d want 0", q_a); end
    n_tests++;
    if (tc_a !== 1'b0) begin n_fail++; $display("FAIL hold_tc: got %b want 0", tc_a); end
  endtask

  // Asynchronous reset mid-count at q=6 with ovf=1.
  task automatic test_async_reset();
    do_reset();
    load = 1'b1; load_val = 4'd15;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = DIR_UP;
    for (int k = 0; k < 7; k++) @(negedge clk);   // 15 -> 0 -> ... -> 6
    n_tests++;
    if (q_a !== 4'd6 || ovf_a !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got q=%0d ovf=%b want q=6 ovf=1", q_a, ovf_a);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (q_a !== 4'd0) begin n_fail++; $display("FAIL async_q: got %0d want 0", q_a); end
    n_tests++;
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL async_ovf: got %b want 0", ovf_a); end
    @(negedge clk);
    n_tests++;
    if (q_a !== 4'd0) begin n_fail++; $display("FAIL reset_held_q: got %0d want 0", q_a); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (q_a !== 4'd1) begin n_fail++; $display("FAIL resume_q: got %0d want 1", q_a); end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = DIR_UP; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
    test_reset();
    test_wrap_up();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_clr_vs_set();
    test_direction();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_updown_mod_counter

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter register width in bits, legal range 1..32.
REQ-002 Parameter MODULUS, default 16: count range is 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 means wrap at the range ends, 1 means hold at the range ends.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port en, input, 1 bit: count enable.
REQ-007 Port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-008 Port load, input, 1 bit: synchronous parallel load request.
REQ-009 Port load_val, input, WIDTH bits: value to load.
REQ-010 Port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-011 Port q, output, WIDTH bits: registered count value.
REQ-012 Port tc, output, 1 bit: terminal-count indication, combinational.
REQ-013 Port ovf, output, 1 bit: sticky flag for a range-end event, registered.

Function
REQ-014 Per-edge priority is load, then en, then hold; when load=1, en and up are ignored.
REQ-015 On load: q <= load_val if load_val < MODULUS, else q <= MODULUS-1 (clamp); ovf is unaffected.
REQ-016 en=1, up=1, q < MODULUS-1: q <= q+1.
REQ-017 en=1, up=0, q > 0: q <= q-1.
REQ-018 en=1, up=1, q = MODULUS-1: q <= 0 when SATURATE=0; q holds when SATURATE=1.
REQ-019 en=1, up=0, q = 0: q <= MODULUS-1 when SATURATE=0; q holds when SATURATE=1.
REQ-020 A range-end event is REQ-018 or REQ-019 occurring with load=0; it sets ovf on the same edge.
REQ-021 clr_ovf=1 clears ovf on the edge; if a range-end event occurs on the same edge, set wins and ovf=1.
REQ-022 tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)); it is high exactly in the cycle before a range-end event.
REQ-023 en=0 and load=0: q holds; up is don't-care; tc=0.
REQ-024 Next-value arithmetic uses WIDTH+1 bits internally, so MODULUS = 2**WIDTH wraps without truncation error.
REQ-025 Counter latency is one clock: the q change is visible after the edge that samples en/load.
REQ-026 Direction changes take effect on the next enabled edge, with no dead cycle.

Reset
REQ-027 rst=0 asynchronously forces q=0 and ovf=0, with no clock required.
REQ-028 rst deasserts synchronously to clk (external synchroniser); the first count occurs on the first rising edge with rst=1 and en=1.
REQ-029 Reset asserted mid-count or mid-load discards the operation; q=0 and ovf=0 hold until release.
REQ-030 During reset tc follows REQ-022 evaluated with q=0.

Structure
REQ-031 Shared package counter_pkg holds the direction constants DIR_UP=1 and DIR_DN=0 and a clog2 helper function.
REQ-032 Single flat module with no sub-module; next-state is one combinational block feeding one registered block.
REQ-033 Elaboration-time check rejects MODULUS > 2**WIDTH or MODULUS < 2.
REQ-034 No derived or gated clocks; this block is the synchronous replacement for ripple-clocked counters.

Verification
REQ-035 WIDTH=4, MODULUS=16, SATURATE=0; reset, then en=1, up=1 for 17 clocks -> q runs 1..15, 0, 1; tc=1 only while q=15; ovf=1 after the wrap.
REQ-036 WIDTH=4, MODULUS=10, SATURATE=0, down from q=0 -> q=9 next, tc=1 at q=0, ovf set; then clr_ovf=1 -> ovf=0.
REQ-037 WIDTH=4, MODULUS=10, SATURATE=1; load 7, then up for 5 clocks -> q=8, 9, 9, 9, 9; ovf=1 after the first hold.
REQ-038 load=1 with load_val=12, MODULUS=10, en=1 -> q=9 (clamp), no count; load_val=3 -> q=3.
REQ-039 clr_ovf=1 on the same edge as a wrap from q=15 -> ovf remains 1.
REQ-040 rst pulsed low mid-cycle at q=6 with ovf=1 -> q=0 and ovf=0 immediately, before the next clk edge; counting resumes from 0 after release.
